reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares the 8-bit register bus (address/bytecnt/read/write/addrvalid) between two masters: the USB register front-end (master 0) and an on-chip requester (master 1), e.g. an auto-configuration or capture sequencer.
- The USB front-end cannot be stalled, so it has absolute, zero-latency priority.
- Master 1 runs multi-byte transactions that are preempted by USB activity and resumed afterwards.
- Sits between the USB front-end and the register blocks such as the trace register block.

Parameters:
- pBYTECNT_SIZE, 7: width of the byte-count and length fields.
- pREAD_LATENCY, 1: slave read-data latency in cycles after the read strobe. Legal values are 0 and 1.

Ports:
- usb_clk  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- usb_address  in  8  master 0 address.
- usb_bytecnt  in  pBYTECNT_SIZE  master 0 byte count.
- usb_write_data  in  8  master 0 write data.
- usb_read  in  1  master 0 read strobe.
- usb_write  in  1  master 0 write strobe.
- usb_addrvalid  in  1  master 0 address valid.
- usb_read_data  out  8  read data to master 0; equals read_data.
- m1_req  in  1  master 1 transaction request (level).
- m1_address  in  8  master 1 register address.
- m1_write  in  1  1 = write transaction, 0 = read transaction.
- m1_len  in  pBYTECNT_SIZE  number of bytes in the transaction.
- m1_wdata  in  8  write data for the current byte.
- m1_gnt  out  1  transaction owned by the arbiter.
- m1_wready  out  1  current write byte consumed this cycle.
- m1_rdata  out  8  returned read byte.
- m1_rvalid  out  1  m1_rdata valid.
- m1_done  out  1  one-cycle completion pulse.
- O_preempt_count  out  8  count of preemptions, saturating.
- reg_address  out  8  slave address.
- reg_bytecnt  out  pBYTECNT_SIZE  slave byte count.
- write_data  out  8  slave write data.
- read_data  in  8  slave read data.
- reg_read  out  1  slave read strobe.
- reg_write  out  1  slave write strobe.
- reg_addrvalid  out  1  slave address valid.

Behaviour:
- Slave mux:
  - While usb_addrvalid=1, all slave outputs pass the usb_* inputs through combinationally, with no added latency.
  - Otherwise the slave outputs are driven by the master-1 FSM.
  - With the FSM idle, slave outputs are all zero.
- FSM states: IDLE, SETUP, XFER, PAUSE, GUARD, RDWAIT.
- IDLE:
  - m1_req=1 and usb_addrvalid=0 → latch m1_address, m1_write and m1_len; clear byte index idx; assert m1_gnt.
  - If the latched length is 0: pulse m1_done the next cycle, return to IDLE, and issue no bus activity.
  - Otherwise go to SETUP.
- SETUP (one cycle): reg_addrvalid=1 and reg_address=latched address, with no strobe. Next state is XFER.
- XFER (one byte per cycle):
  - Drive reg_addrvalid=1 and reg_bytecnt=idx.
  - Write transaction: reg_write=1, write_data=m1_wdata, m1_wready=1.
  - Read transaction: reg_read=1.
  - idx increments after each issued byte.
  - After the last byte (idx=len-1):
    - Write transaction: go to IDLE and pulse m1_done.
    - Read transaction, pREAD_LATENCY=1: go to RDWAIT.
    - Read transaction, pREAD_LATENCY=0: go to IDLE and pulse m1_done.
- Read data return: m1_rvalid is asserted pREAD_LATENCY cycles after each read strobe, with m1_rdata=read_data. The return happens even if USB preempts in the return cycle.
- RDWAIT: capture the last byte, pulse m1_done together with the final m1_rvalid, then go to IDLE.
- m1_gnt deasserts in the same cycle as m1_done. A new request is accepted no earlier than the following cycle.
- Preemption:
  - If usb_addrvalid=1 in any SETUP or XFER cycle, that byte is not issued: no strobe from master 1, no m1_wready, idx unchanged.
  - The FSM goes to PAUSE and O_preempt_count increments, saturating at 255.
- PAUSE: holds while usb_addrvalid=1. When it falls, go to GUARD.
- GUARD (one idle cycle): next state is SETUP, unless usb_addrvalid rose again, in which case go back to PAUSE. Resumption restarts at the saved idx.
- RDWAIT is not preemptible.
- m1_req is ignored outside IDLE. Deasserting m1_req mid-transaction does not abort it.
- Reset (asynchronous, usable at any time, including mid-transaction):
  - FSM=IDLE, idx=0, O_preempt_count=0.
  - m1_gnt, m1_wready, m1_rvalid, m1_done=0; m1_rdata=0.
  - Slave outputs revert to USB passthrough or zero.
  - The aborted transaction produces no m1_done.

Test Plan:
- Write, no contention: m1 writes len=4 to address 0x0A with bytes 11,22,33,44 → SETUP for 1 cycle, then 4 consecutive reg_write strobes with bytecnt 0..3; m1_done 4 cycles after SETUP; slave register reads back 0x44332211.
- Read of 8 bytes, pREAD_LATENCY=1: address 0x00 on the trace register block → 8 m1_rvalid pulses carrying 0x41,0x72,0x6d,0x54,0x72,0x61,0x63,0x65 ('ArmTrace'); m1_done coincides with the 8th pulse.
- Preemption: usb_addrvalid rises after byte 1 of a 4-byte write, and a USB write of 0x05 to address 0x02 completes → USB write passes through unaltered; m1 resumes at bytecnt 2 after PAUSE, GUARD and SETUP; O_preempt_count=1; all 4 bytes land correctly.
- Simultaneous start: m1_req and usb_addrvalid rise in the same cycle → no grant until usb_addrvalid falls; then the grant follows within 1 cycle.
- Zero length: m1_len=0 → m1_done 1 cycle after the grant, with no reg_read or reg_write strobes.
- Reset mid-transaction: reset_i pulsed during byte 2 of a read → all outputs 0 immediately; no m1_done; the next request completes normally.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Register-bus arbiter signal bundle.
// Carries the USB front-end bus (master 0), the on-chip requester handshake
// (master 1), the shared slave-side register bus and the preemption counter.
//   modport slave  : the arbiter's view (it serves both masters)
//   modport master : the environment's view (USB front-end, requester, slaves)
interface reg_bus_arbiter_if #(
    parameter int pBYTECNT_SIZE = 7
);
    // master 0: USB register front-end
    logic [7:0]               usb_address;
    logic [pBYTECNT_SIZE-1:0] usb_bytecnt;
    logic [7:0]               usb_write_data;
    logic                     usb_read;
    logic                     usb_write;
    logic                     usb_addrvalid;
    logic [7:0]               usb_read_data;
    // master 1: on-chip requester
    logic                     m1_req;
    logic [7:0]               m1_address;
    logic                     m1_write;
    logic [pBYTECNT_SIZE-1:0] m1_len;
    logic [7:0]               m1_wdata;
    logic                     m1_gnt;
    logic                     m1_wready;
    logic [7:0]               m1_rdata;
    logic                     m1_rvalid;
    logic                     m1_done;
    logic [7:0]               O_preempt_count;
    // slave-side register bus
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;

    modport slave (
        input  usb_address, usb_bytecnt, usb_write_data, usb_read, usb_write, usb_addrvalid,
        output usb_read_data,
        input  m1_req, m1_address, m1_write, m1_len, m1_wdata,
        output m1_gnt, m1_wready, m1_rdata, m1_rvalid, m1_done, O_preempt_count,
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  read_data
    );

    modport master (
        output usb_address, usb_bytecnt, usb_write_data, usb_read, usb_write, usb_addrvalid,
        input  usb_read_data,
        output m1_req, m1_address, m1_write, m1_len, m1_wdata,
        input  m1_gnt, m1_wready, m1_rdata, m1_rvalid, m1_done, O_preempt_count,
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output read_data
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Register-bus arbiter.
// Shares the 8-bit register bus between the USB front-end (master 0, absolute
// zero-latency priority, never stalled) and an on-chip requester (master 1)
// whose multi-byte transactions are preempted by USB activity and resumed at
// the byte where they stopped.
// Ports:
//   usb_clk  : clock
//   reset_i  : asynchronous active-high reset
//   bus      : reg_bus_arbiter_if.slave (USB bus, requester handshake,
//              slave bus, preemption counter)
module reg_bus_arbiter #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = 1   // 0 or 1
) (
    input  logic             usb_clk,
    input  logic             reset_i,
    reg_bus_arbiter_if.slave bus
);
    localparam int            BC     = pBYTECNT_SIZE;
    localparam logic [BC-1:0] BC_ONE = BC'(1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, PAUSE, GUARD, RDWAIT} state_t;

    state_t        state_q, state_d;
    logic [BC-1:0] idx_q, idx_d;
    logic [BC-1:0] len_q, len_d;
    logic [7:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          zdone_q, zdone_d;   // done pulse for a zero-length transaction
    logic          rd_q;               // master-1 read strobe issued last cycle

    logic          accept, done, wready, last;
    logic          m1_av, m1_rd, m1_wr;
    logic [7:0]    m1_addr;
    logic [BC-1:0] m1_bc;
    logic          rvalid;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            pcnt_q  <= '0;
            zdone_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            pcnt_q  <= pcnt_d;
            zdone_q <= zdone_d;
            rd_q    <= m1_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        pcnt_d  = pcnt_q;
        zdone_d = 1'b0;
        accept  = 1'b0;
        done    = 1'b0;
        wready  = 1'b0;
        m1_av   = 1'b0;
        m1_rd   = 1'b0;
        m1_wr   = 1'b0;
        m1_addr = '0;
        m1_bc   = '0;
        last    = (idx_q == len_q - BC_ONE);
        case (state_q)
            IDLE: begin
                // zdone_q blocks acceptance in the cycle a zero-length done is shown
                if (bus.m1_req && !bus.usb_addrvalid && !zdone_q && !reset_i) begin
                    accept = 1'b1;
                    addr_d = bus.m1_address;
                    wr_d   = bus.m1_write;
                    len_d  = bus.m1_len;
                    idx_d  = '0;
                    if (bus.m1_len == '0) zdone_d = 1'b1;
                    else                  state_d = SETUP;
                end
            end
            SETUP, XFER: begin
                if (bus.usb_addrvalid) begin
                    // USB owns this cycle: drop the byte, keep idx for resumption
                    state_d = PAUSE;
                    pcnt_d  = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
                end else if (state_q == SETUP) begin
                    m1_av   = 1'b1;
                    m1_addr = addr_q;
                    state_d = XFER;
                end else begin
                    m1_av   = 1'b1;
                    m1_addr = addr_q;
                    m1_bc   = idx_q;
                    if (wr_q) begin
                        m1_wr  = 1'b1;
                        wready = 1'b1;
                    end else begin
                        m1_rd  = 1'b1;
                    end
                    idx_d = idx_q + BC_ONE;
                    if (last) begin
                        if (wr_q || pREAD_LATENCY == 0) begin
                            state_d = IDLE;
                            done    = 1'b1;
                        end else begin
                            state_d = RDWAIT;
                        end
                    end
                end
            end
            PAUSE:  if (!bus.usb_addrvalid) state_d = GUARD;
            GUARD:  state_d = bus.usb_addrvalid ? PAUSE : SETUP;
            RDWAIT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // USB passes straight through whenever it claims the bus
    always_comb begin
        if (bus.usb_addrvalid) begin
            bus.reg_address   = bus.usb_address;
            bus.reg_bytecnt   = bus.usb_bytecnt;
            bus.write_data    = bus.usb_write_data;
            bus.reg_read      = bus.usb_read;
            bus.reg_write     = bus.usb_write;
            bus.reg_addrvalid = 1'b1;
        end else begin
            bus.reg_address   = m1_addr;
            bus.reg_bytecnt   = m1_bc;
            bus.write_data    = m1_wr ? bus.m1_wdata : 8'h00;
            bus.reg_read      = m1_rd;
            bus.reg_write     = m1_wr;
            bus.reg_addrvalid = m1_av;
        end
    end

    // read return is tied to the strobe, not the state, so it survives preemption
    assign rvalid              = (pREAD_LATENCY == 0) ? m1_rd : rd_q;
    assign bus.m1_rvalid       = rvalid;
    assign bus.m1_rdata        = rvalid ? bus.read_data : 8'h00;
    assign bus.usb_read_data   = bus.read_data;
    assign bus.m1_gnt          = accept | (state_q != IDLE) | zdone_q;
    assign bus.m1_done         = done | zdone_q;
    assign bus.m1_wready       = wready;
    assign bus.O_preempt_count = pcnt_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed transactions plus a transaction-level
// model (expected beat / read-data queues built at grant time) compared every
// cycle, and a register-file slave with one-cycle read latency.
module tb_reg_bus_arbiter;
    localparam int BC = 7;
    localparam logic [63:0] TRACE = 64'h4172_6d54_7261_6365;  // "ArmTrace"

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_arbiter_if #(.pBYTECNT_SIZE(BC)) bus();

    reg_bus_arbiter #(.pBYTECNT_SIZE(BC), .pREAD_LATENCY(1)) dut (
        .usb_clk (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    function automatic logic [7:0] trace_byte(input int i);
        return TRACE[63-8*i -: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- slave: register file, address 0 is the trace ROM
    logic [7:0] smem [0:15][0:7];
    logic [7:0] rdq = 8'h00;
    always @(posedge clk) begin
        if (bus.reg_write) smem[bus.reg_address[3:0]][bus.reg_bytecnt[2:0]] <= bus.write_data;
        if (bus.reg_read)
            rdq <= (bus.reg_address == 8'h00) ? trace_byte(int'(bus.reg_bytecnt[2:0]))
                                              : smem[bus.reg_address[3:0]][bus.reg_bytecnt[2:0]];
    end
    assign bus.read_data = rdq;

    // ---------------- requester write-data source
    logic [7:0] wbuf [0:7];
    logic [2:0] widx;
    always @(posedge clk or posedge rst) begin
        if (rst)                widx <= 3'd0;
        else if (bus.m1_done)   widx <= 3'd0;
        else if (bus.m1_wready) widx <= widx + 3'd1;
    end
    assign bus.m1_wdata = wbuf[widx];

    // ---------------- transaction-level model and per-cycle compare
    typedef struct {
        logic [7:0]    a;
        logic [BC-1:0] i;
        logic [7:0]    d;
    } beat_t;
    beat_t      wq[$];
    beat_t      rq[$];
    logic [7:0] dq[$];
    bit         busy = 1'b0;

    initial begin : model
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                wq.delete(); rq.delete(); dq.delete();
                busy = 1'b0;
            end else begin
                chk("usb_read_data", 32'(bus.usb_read_data), 32'(bus.read_data));
                if (bus.usb_addrvalid) begin
                    chk("pass_ctl", 32'({bus.reg_addrvalid, bus.reg_read, bus.reg_write}),
                        32'({1'b1, bus.usb_read, bus.usb_write}));
                    chk("pass_data", {8'h0, bus.reg_address, 1'b0, bus.reg_bytecnt, bus.write_data},
                        {8'h0, bus.usb_address, 1'b0, bus.usb_bytecnt, bus.usb_write_data});
                    chk("wready_preempt", 32'(bus.m1_wready), 32'd0);
                end else if (bus.reg_write) begin
                    chk("wr_expected", 32'(wq.size() != 0), 32'd1);
                    if (wq.size() != 0) begin
                        b = wq.pop_front();
                        chk("wr_beat", {8'h0, bus.reg_address, 1'b0, bus.reg_bytecnt, bus.write_data},
                            {8'h0, b.a, 1'b0, b.i, b.d});
                    end
                    chk("wready_wr", 32'(bus.m1_wready), 32'd1);
                end else if (bus.reg_read) begin
                    chk("rd_expected", 32'(rq.size() != 0), 32'd1);
                    if (rq.size() != 0) begin
                        b = rq.pop_front();
                        chk("rd_beat", {16'h0, bus.reg_address, 1'b0, bus.reg_bytecnt},
                            {16'h0, b.a, 1'b0, b.i});
                    end
                    chk("wready_rd", 32'(bus.m1_wready), 32'd0);
                end else begin
                    chk("wready_none", 32'(bus.m1_wready), 32'd0);
                end
                if (!busy && !bus.usb_addrvalid)
                    chk("idle_bus", {6'h0, bus.reg_addrvalid, bus.reg_read, bus.reg_write,
                                     bus.reg_address, bus.reg_bytecnt, bus.write_data}, 32'd0);
                if (bus.m1_rvalid) begin
                    chk("rvalid_expected", 32'(dq.size() != 0), 32'd1);
                    if (dq.size() != 0) chk("rdata", 32'(bus.m1_rdata), 32'(dq.pop_front()));
                end
                if (bus.m1_done) begin
                    chk("done_busy", 32'(busy), 32'd1);
                    chk("done_drained", 32'(wq.size() + rq.size() + dq.size()), 32'd0);
                    busy = 1'b0;
                end else if (!busy && bus.m1_gnt) begin
                    busy = 1'b1;
                    for (int i = 0; i < int'(bus.m1_len); i++) begin
                        b.a = bus.m1_address;
                        b.i = BC'(i);
                        b.d = bus.m1_write ? wbuf[i[2:0]] : 8'h00;
                        if (bus.m1_write) wq.push_back(b);
                        else begin
                            rq.push_back(b);
                            dq.push_back(trace_byte(i));
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus
    task automatic start(input logic w, input logic [7:0] a, input logic [BC-1:0] len, output int g);
        bus.m1_write = w; bus.m1_address = a; bus.m1_len = len; bus.m1_req = 1'b1;
        g = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.m1_gnt) begin g = cyc; break; end
        end
        chk("grant_timeout", 32'(g >= 0), 32'd1);
        @(posedge clk); #1;
        bus.m1_req = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output int nrv, output logic [63:0] rdat, output int nstb);
        dcyc = -1; nrv = 0; rdat = '0; nstb = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.usb_addrvalid && (bus.reg_read || bus.reg_write)) nstb++;
            if (bus.m1_rvalid) begin rdat = {rdat[55:0], bus.m1_rdata}; nrv++; end
            if (bus.m1_done) begin dcyc = cyc; break; end
        end
        chk("done_timeout", 32'(dcyc >= 0), 32'd1);
    endtask

    task automatic usb_idle();
        bus.usb_addrvalid = 1'b0; bus.usb_read = 1'b0; bus.usb_write = 1'b0;
        bus.usb_address = 8'h00; bus.usb_bytecnt = '0; bus.usb_write_data = 8'h00;
    endtask

    initial begin : stim
        int g, d, nrv, nstb, nd;
        logic [63:0] rdat;
        usb_idle();
        bus.m1_req = 1'b0; bus.m1_write = 1'b0; bus.m1_address = 8'h00; bus.m1_len = '0;
        for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m1", 32'({bus.m1_gnt, bus.m1_wready, bus.m1_rvalid, bus.m1_done}), 32'd0);
        chk("rst_rdata_cnt", {16'h0, bus.m1_rdata, bus.O_preempt_count}, 32'd0);
        chk("rst_slave", 32'({bus.reg_addrvalid, bus.reg_read, bus.reg_write, bus.reg_address}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // write len 4 to 0x0A, no contention
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        start(1'b1, 8'h0A, 7'd4, g);
        @(negedge clk);
        chk("wr_setup", 32'({bus.reg_addrvalid, bus.reg_read, bus.reg_write, bus.reg_address}),
            32'({1'b1, 1'b0, 1'b0, 8'h0A}));
        wait_done(d, nrv, rdat, nstb);
        chk("wr_done_latency", d - g, 32'd5);
        chk("wr_strobes", nstb, 32'd4);
        @(posedge clk); #1;
        chk("wr_gnt_drop", 32'(bus.m1_gnt), 32'd0);
        chk("wr_mem", {smem[10][3], smem[10][2], smem[10][1], smem[10][0]}, 32'h44332211);

        // read 8 bytes of the trace block
        start(1'b0, 8'h00, 7'd8, g);
        wait_done(d, nrv, rdat, nstb);
        chk("rd_pulses", nrv, 32'd8);
        chk("rd_done_with_rvalid", 32'(bus.m1_rvalid), 32'd1);
        chk("rd_data_hi", rdat[63:32], 32'h41726d54);
        chk("rd_data_lo", rdat[31:0], 32'h72616365);
        chk("rd_done_latency", d - g, 32'd10);
        @(posedge clk); #1;

        // write preempted after byte 1 by a USB write of 0x05 to 0x02
        wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3; wbuf[3] = 8'hD4;
        start(1'b1, 8'h03, 7'd4, g);            // now in SETUP
        repeat (3) begin @(posedge clk); #1; end // bytes 0,1 issued; now cycle of byte 2
        bus.usb_addrvalid = 1'b1; bus.usb_write = 1'b1;
        bus.usb_address = 8'h02; bus.usb_write_data = 8'h05;
        @(posedge clk); #1;
        bus.usb_write = 1'b0;
        @(posedge clk); #1;
        usb_idle();
        wait_done(d, nrv, rdat, nstb);
        chk("pre_done_latency", d - g, 32'd10);
        chk("pre_count", 32'(bus.O_preempt_count), 32'd1);
        @(posedge clk); #1;
        chk("pre_mem", {smem[3][3], smem[3][2], smem[3][1], smem[3][0]}, 32'hD4C3B2A1);
        chk("pre_usb_mem", 32'(smem[2][0]), 32'h05);

        // simultaneous request and USB activity
        wbuf[0] = 8'h5A;
        bus.usb_address = 8'h07; bus.usb_addrvalid = 1'b1;
        bus.m1_write = 1'b1; bus.m1_address = 8'h05; bus.m1_len = 7'd1; bus.m1_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("simul_no_gnt", 32'(bus.m1_gnt), 32'd0);
            @(posedge clk); #1;
        end
        usb_idle();
        @(negedge clk);
        chk("simul_gnt", 32'(bus.m1_gnt), 32'd1);
        g = cyc;
        @(posedge clk); #1;
        bus.m1_req = 1'b0;
        wait_done(d, nrv, rdat, nstb);
        chk("simul_done_latency", d - g, 32'd2);
        chk("simul_count", 32'(bus.O_preempt_count), 32'd1);
        @(posedge clk); #1;
        chk("simul_mem", 32'(smem[5][0]), 32'h5A);

        // zero length
        start(1'b1, 8'h06, 7'd0, g);
        wait_done(d, nrv, rdat, nstb);
        chk("zero_done_latency", d - g, 32'd1);
        chk("zero_strobes", nstb, 32'd0);
        @(posedge clk); #1;
        chk("zero_gnt_drop", 32'(bus.m1_gnt), 32'd0);

        // repeated preemption in SETUP saturates the counter
        wbuf[0] = 8'h9C; wbuf[1] = 8'h9D;
        start(1'b1, 8'h09, 7'd2, g);            // now in SETUP
        repeat (300) begin
            bus.usb_addrvalid = 1'b1;
            @(posedge clk); #1;
            bus.usb_addrvalid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end
        wait_done(d, nrv, rdat, nstb);
        chk("sat_count", 32'(bus.O_preempt_count), 32'd255);
        @(posedge clk); #1;
        chk("sat_mem", 32'({smem[9][1], smem[9][0]}), 32'h9D9C);

        // reset during byte 2 of a read
        start(1'b0, 8'h00, 7'd8, g);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("mid_rst_m1", 32'({bus.m1_gnt, bus.m1_wready, bus.m1_rvalid, bus.m1_done}), 32'd0);
        chk("mid_rst_slave", 32'({bus.reg_addrvalid, bus.reg_read, bus.reg_write, bus.reg_address}), 32'd0);
        chk("mid_rst_count", 32'(bus.O_preempt_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        repeat (20) begin @(negedge clk); if (bus.m1_done) nd++; end
        chk("mid_rst_no_done", nd, 32'd0);
        @(posedge clk); #1;
        start(1'b0, 8'h00, 7'd8, g);
        wait_done(d, nrv, rdat, nstb);
        chk("post_rst_pulses", nrv, 32'd8);
        chk("post_rst_data_hi", rdat[63:32], 32'h41726d54);
        chk("post_rst_data_lo", rdat[31:0], 32'h72616365);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
